// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loader that fills program memory and holds the CPU until done
// Optional checksum word after the payload: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  CpuHold,
    output logic                  Done,
    output logic                  Error
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_LOAD, S_CHECK, S_FLUSH, S_DONE} state_t;
    logic [31:0] sum;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_LOAD, S_FLUSH, S_DONE} state_t;
`endif

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           shift;
    logic [DATA_WIDTH-1:0] word_count;
    logic [DATA_WIDTH-1:0] word_index;
    logic [31:0]           word;
    logic                  accept;
    logic                  word_done;

    // Assembled word is only meaningful when the 4th byte is on ByteIn.
    assign accept    = ByteValid && ByteReady;
    assign word      = {shift, ByteIn};
    assign word_done = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            byte_cnt     <= 2'd0;
            shift        <= '0;
            word_count   <= '0;
            word_index   <= '0;
            ByteReady    <= 1'b0;
            MemWrite     <= 1'b0;
            MemAddress   <= BASE_ADDRESS;
            MemWriteData <= '0;
            CpuHold      <= 1'b1;
            Done         <= 1'b0;
            Error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            MemWrite <= 1'b0;
            if (accept) begin
                shift    <= {shift[15:0], ByteIn};
                byte_cnt <= byte_cnt + 2'd1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state      <= S_HEADER;
                        ByteReady  <= 1'b1;
                        CpuHold    <= 1'b1;
                        Done       <= 1'b0;
                        Error      <= 1'b0;
                        word_index <= '0;
                        byte_cnt   <= 2'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                S_HEADER: begin
                    if (word_done) begin
                        word_count <= word;
                        if (word == 32'd0) begin
                            state     <= S_DONE;
                            ByteReady <= 1'b0;
                            Done      <= 1'b1;
                            CpuHold   <= 1'b0;
                        end else if (word > 32'(MEMORY_DEPTH)) begin
                            state     <= S_DONE;
                            ByteReady <= 1'b0;
                            Done      <= 1'b1;
                            Error     <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (word_done) begin
                        MemWrite     <= 1'b1;
                        MemWriteData <= word;
                        MemAddress   <= BASE_ADDRESS + (word_index << 2);
                        word_index   <= word_index + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum          <= sum + word;
                        if (word_index + 32'd1 == word_count)
                            state <= S_CHECK;
`else
                        if (word_index + 32'd1 == word_count) begin
                            state     <= S_FLUSH;
                            ByteReady <= 1'b0;
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (word_done) begin
                        state     <= S_DONE;
                        ByteReady <= 1'b0;
                        Done      <= 1'b1;
                        Error     <= (word != sum);
                        CpuHold   <= (word != sum);
                    end
                end
`endif
                // Last write pulse is on the bus this cycle; Done follows it.
                S_FLUSH: begin
                    state   <= S_DONE;
                    Done    <= 1'b1;
                    CpuHold <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
